// File: rtl/multu_hilo_pkg.sv
// Shared constants for the multiply / HI-LO block: ALU function codes and FSM states.
package multu_hilo_pkg;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_HI    = 6'd16;
  localparam logic [5:0] FN_LO    = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;
  // Group codes the control stage emits for generic ALU / shifter operations.
  localparam logic [5:0] FN_ALU   = 6'd48;
  localparam logic [5:0] FN_SHIFT = 6'd49;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/multu_hilo_if.sv
// Function-code / operand / result bundle between ALU control and the multiplier.
interface multu_hilo_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       sltMul;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output sltMul, dataA, dataB,
    input  busy, done, hi, lo
  );

  modport slave (
    input  sltMul, dataA, dataB,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/multu_hilo_datapath.sv
// Radix-2 shift-add datapath: product accumulator, shifting multiplicand/multiplier, iteration counter.
module multu_hilo_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_nxt_o,
  output logic               last_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      // Multiplicand never exceeds 2*WIDTH bits after WIDTH shifts, so the add cannot overflow.
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign prod_nxt_o = prod_d;
  assign last_o     = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned multiplier with HI/LO result register; starts on a rising MULTU function code.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] MULTU_CODE = FN_MULTU
) (
  input  logic         clk,
  input  logic         rst_n,
  multu_hilo_if.slave  bus
);

  state_e           state_q, state_d;
  logic [5:0]       prev_q, prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               start;
  logic               load;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] prod_nxt;

  // Edge-detect on the code so a MULTU held for many cycles launches one multiply only.
  assign start  = (bus.sltMul == MULTU_CODE) && (prev_q != MULTU_CODE);
  assign prev_d = bus.sltMul;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last) begin
          hi_d    = prod_nxt[2*WIDTH-1:WIDTH];
          lo_d    = prod_nxt[WIDTH-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  multu_hilo_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .a_i        (bus.dataA),
    .b_i        (bus.dataB),
    .prod_nxt_o (prod_nxt),
    .last_o     (last)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_multu_hilo.sv
// Directed plus random stimulus for multu_hilo against a cycle-count/arithmetic reference model.
module tb_multu_hilo;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multu_hilo_if #(.WIDTH(W)) bus ();

  multu_hilo #(.WIDTH(W), .MULTU_CODE(6'd25)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: an accepted start launches a W-cycle countdown, then HI:LO = a*b.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;
  logic [5:0]    m_prev = '0;
  int            m_rem = 0;
  logic [63:0]   m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0;
      m_prev <= '0; m_rem <= 0; m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_prod[63:32];
          m_lo   <= m_prod[31:0];
        end
        m_rem <= m_rem - 1;
      end else if (bus.sltMul == 6'd25 && m_prev != 6'd25) begin
        m_busy <= 1'b1;
        m_rem  <= W;
        m_prod <= 64'(bus.dataA) * 64'(bus.dataB);
      end
      m_prev <= bus.sltMul;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_model();
    chk("model_busy", 64'(bus.busy), 64'(m_busy));
    chk("model_done", 64'(bus.done), 64'(m_done));
    chk("model_hi",   64'(bus.hi),   64'(m_hi));
    chk("model_lo",   64'(bus.lo),   64'(m_lo));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (bus.done === 1'b1) done_cnt++;
    check_model();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < W + 8) begin
      cyc();
      n++;
    end
    chk(tag, 64'(bus.done), 64'd1);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.sltMul = 6'd0;
    cyc();
    bus.dataA  = a;
    bus.dataB  = b;
    bus.sltMul = 6'd25;
    cyc();
  endtask

  initial begin
    int n;
    int d0;
    logic [W-1:0] ra, rb;
    bus.sltMul = 6'd0;
    bus.dataA  = '0;
    bus.dataB  = '0;

    // Reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi",   64'(bus.hi),   64'd0);
    chk("rst_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3*5: busy for exactly W cycles, done at edge W after start
    bus.dataA = 32'd3; bus.dataB = 32'd5; bus.sltMul = 6'd25;
    cyc();
    n = 1;
    while (bus.done !== 1'b1 && n < W + 8) begin
      chk("small_busy_during", 64'(bus.busy), 64'd1);
      cyc();
      n++;
    end
    chk("small_latency", 64'(n), 64'(W + 1));
    chk("small_hi", 64'(bus.hi), 64'd0);
    chk("small_lo", 64'(bus.lo), 64'd15);
    cyc();
    chk("small_done_falls", 64'(bus.done), 64'd0);

    // All-ones and zero operand
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("ones_done");
    chk("ones_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    chk("ones_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
    start_op(32'd0, 32'h1234_5678);
    wait_done("zero_done");
    chk("zero_hi", 64'(bus.hi), 64'd0);
    chk("zero_lo", 64'(bus.lo), 64'd0);

    // Held MULTU for 100 cycles with operands changing mid-run
    start_op(32'd7, 32'd9);
    d0 = done_cnt;
    for (int i = 0; i < 100; i++) begin
      if (i == 2) begin
        bus.dataA = $urandom;
        bus.dataB = $urandom;
      end
      cyc();
    end
    chk("held_one_done", 64'(done_cnt - d0), 64'd1);
    chk("held_lo", 64'(bus.lo), 64'd63);
    chk("held_hi", 64'(bus.hi), 64'd0);

    // Restart attempt during RUN is ignored
    start_op(32'd4, 32'd6);
    d0 = done_cnt;
    repeat (9) cyc();
    bus.sltMul = 6'd32;
    cyc();
    bus.sltMul = 6'd25;
    cyc();
    wait_done("restart_done");
    chk("restart_lo", 64'(bus.lo), 64'd24);
    repeat (40) cyc();
    chk("restart_single", 64'(done_cnt - d0), 64'd1);
    chk("restart_idle", 64'(bus.busy), 64'd0);

    // Non-MULTU codes never start anything
    bus.sltMul = 6'd32; repeat (3) cyc();
    bus.sltMul = 6'd36; repeat (3) cyc();
    bus.sltMul = 6'd2;  repeat (3) cyc();
    chk("other_busy", 64'(bus.busy), 64'd0);
    chk("other_lo", 64'(bus.lo), 64'd24);

    // Reset mid-operation
    start_op(32'd11, 32'd13);
    repeat (15) cyc();
    rst_n = 1'b0;
    bus.sltMul = 6'd0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi",   64'(bus.hi),   64'd0);
    chk("midrst_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'd2, 32'h8000_0000);
    wait_done("postrst_done");
    chk("postrst_hi", 64'(bus.hi), 64'd1);
    chk("postrst_lo", 64'(bus.lo), 64'd0);

    // Back-to-back: start in the done cycle
    start_op(32'd10, 32'd11);
    bus.sltMul = 6'd0;
    wait_done("b2b_first_done");
    chk("b2b_first_lo", 64'(bus.lo), 64'd110);
    bus.dataA = 32'd1000; bus.dataB = 32'd3000; bus.sltMul = 6'd25;
    cyc();
    chk("b2b_busy_rise", 64'(bus.busy), 64'd1);
    chk("b2b_done_fall", 64'(bus.done), 64'd0);
    bus.sltMul = 6'd0;
    repeat (5) cyc();
    chk("b2b_hold_lo", 64'(bus.lo), 64'd110);
    wait_done("b2b_second_done");
    chk("b2b_second_hi", 64'(bus.hi), 64'd0);
    chk("b2b_second_lo", 64'(bus.lo), 64'd3000000);

    // Random operands
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = $urandom;
      start_op(ra, rb);
      bus.sltMul = 6'($urandom_range(26, 63));
      wait_done("rand_done");
      chk("rand_prod", {bus.hi, bus.lo}, 64'(ra) * 64'(rb));
    end
    repeat (3) cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multu_hilo.md
Name: multu_hilo

Overview:
- Sequential unsigned multiplier plus HI/LO result register. Sits directly downstream of the ALU control stage.
- Consumes the registered function code on sltMul. Starts a multiply when it sees the MULTU code.
- Runs a radix-2 shift-add over WIDTH cycles, then writes the 2*WIDTH-bit product into HI/LO.
- HI/LO feed the result mux when the HI/LO read codes select them.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
- MULTU_CODE, 6'd25, function code that requests a multiply.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sltMul  input  6  registered function code from the ALU control stage
- dataA  input  WIDTH  multiplicand operand
- dataB  input  WIDTH  multiplier operand
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse; HI/LO just updated
- hi  output  WIDTH  upper half of the last completed product
- lo  output  WIDTH  lower half of the last completed product

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n); all state is in the clk domain.
- Reset values:
  - state=IDLE, busy=0, done=0, hi=0, lo=0.
  - Internal product, multiplicand, multiplier and counter all 0.
  - prevMul (registered copy of sltMul) = 0.
- Start detection:
  - start = (sltMul==MULTU_CODE) && (prevMul!=MULTU_CODE).
  - prevMul <= sltMul every cycle.
  - A code held at MULTU for many cycles therefore yields exactly one multiply.
  - After reset, an already-present MULTU yields one start.
- States:
  - IDLE: done=0 except in the completion cycle (see below).
    - On start, latch mcand = {WIDTH zeros, dataA} (2*WIDTH bits), mplier = dataB, prod = 0, cnt = 0; go to RUN and set busy=1.
    - Operands are sampled only at this edge.
  - RUN, each edge:
    - If mplier[0], prod <= prod + mcand (2*WIDTH-bit add; cannot overflow).
    - mcand <<= 1; mplier >>= 1; cnt++.
    - On the edge where cnt==WIDTH-1 (the last iteration), the final prod value including this iteration's add is written: hi <= prod_next[2W-1:W], lo <= prod_next[W-1:0].
    - On that same edge: busy <= 0, done <= 1, state <= IDLE.
  - The completion cycle is an IDLE cycle with done=1. done clears on the next edge.
- Latency:
  - Start is sampled at edge E.
  - busy=1 from E through edge E+WIDTH, i.e. WIDTH cycles.
  - done=1 and new hi/lo are visible after edge E+WIDTH (33 edges after start for WIDTH=32).
- hi/lo hold their previous values throughout RUN and change only at completion.
- A start edge during RUN (MULTU re-asserted after a gap) is ignored. No queueing.
- A start edge in the done cycle is accepted normally; done still falls at the next edge.
- Non-MULTU codes (ALU, shift, HI, LO reads) never alter busy, hi or lo.
- Reset asserted mid-operation: immediate abort; all outputs return to their reset values asynchronously.
- Counter width is clog2(WIDTH)+1 bits. No wrap: it is cleared at every start.

Decomposition:
- Shared package holds the function-code constants (AND, OR, ADD, SUB, SLT, SRL, SLL, MULTU, ALU, SHIFT, HI, LO) and the state enum (IDLE, RUN).
- Natural sub-module: mul_datapath (shift-add registers and adder), controlled by the FSM in multu_hilo.
- A single flat module is also acceptable.

Test Plan:
- Small operands: rst_n pulse, then dataA=3, dataB=5, sltMul 0->25 -> busy high 32 cycles; done pulses once 33 edges after start; hi=0, lo=15.
- All-ones operands: dataA=dataB=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Also dataA=0, dataB=32'h12345678 -> hi=lo=0.
- Held MULTU code: sltMul held at 25 for 100 cycles -> exactly one done pulse. Changing dataA/dataB during RUN does not affect the result (7*9 -> lo=63).
- Restart attempt during RUN: at cycle 10 of RUN, sltMul 25->32->25 -> ignored; the first result completes on schedule, then no second done. Codes 32/36/2 alone never raise busy.
- Reset mid-operation: rst_n low at RUN cycle 16 -> busy=0, done=0, hi=lo=0 immediately. After release with sltMul=0 then 25, dataA=2, dataB=32'h80000000 -> hi=1, lo=0.
- Back-to-back operations: start in the done cycle -> accepted; busy rises on the next edge; the second result is correct and the first result is held until the second completes.
